// File: rtl/fwd_history_mux.sv
// Operand-forwarding unit: tracks the last DEPTH register writes and resolves rs/rt operands
// to the newest in-flight result, falling back to register-file data. Outputs are registered.
module fwd_history_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 5,
  localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]  wr_data_in,
  input  logic              op_valid_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [WIDTH-1:0]  rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [WIDTH-1:0]  rt_data,
  output logic [WIDTH-1:0]  op1_out,
  output logic [WIDTH-1:0]  op2_out,
  output logic [SEL_W-1:0]  fwd_sel_rs,
  output logic [SEL_W-1:0]  fwd_sel_rt,
  output logic              op_valid_out,
  output logic [15:0]       fwd_count
);

  // Entry 0 is the newest result.
  logic              hist_vld_q  [DEPTH];
  logic [ADDR_W-1:0] hist_addr_q [DEPTH];
  logic [WIDTH-1:0]  hist_data_q [DEPTH];

  logic [WIDTH-1:0] op1_q, op2_q;
  logic [SEL_W-1:0] sel_rs_q, sel_rt_q;
  logic             op_vld_q;
  logic [15:0]      cnt_q;

  logic [SEL_W-1:0] sel_rs_d, sel_rt_d;
  logic [WIDTH-1:0] op1_d, op2_d;
  logic [1:0]       fwd_inc;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_d;

  // Walk oldest to newest so the newest matching entry is the one that sticks.
  always_comb begin
    sel_rs_d = '0;
    op1_d    = rs_data;
    sel_rt_d = '0;
    op2_d    = rt_data;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hist_vld_q[i] && (hist_addr_q[i] == rs_addr) && (rs_addr != '0)) begin
        sel_rs_d = SEL_W'(i + 1);
        op1_d    = hist_data_q[i];
      end
      if (hist_vld_q[i] && (hist_addr_q[i] == rt_addr) && (rt_addr != '0)) begin
        sel_rt_d = SEL_W'(i + 1);
        op2_d    = hist_data_q[i];
      end
    end
  end

  always_comb begin
    fwd_inc = {1'b0, (sel_rs_d != '0)} + {1'b0, (sel_rt_d != '0)};
    cnt_sum = {1'b0, cnt_q} + {15'b0, fwd_inc};
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_vld_q[i]  <= 1'b0;
        hist_addr_q[i] <= '0;
        hist_data_q[i] <= '0;
      end
      op1_q    <= '0;
      op2_q    <= '0;
      sel_rs_q <= '0;
      sel_rt_q <= '0;
      op_vld_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      // Flush wins over stall; the forwarded-operand count is preserved.
      for (int i = 0; i < DEPTH; i++) begin
        hist_vld_q[i] <= 1'b0;
      end
      op1_q    <= '0;
      op2_q    <= '0;
      sel_rs_q <= '0;
      sel_rt_q <= '0;
      op_vld_q <= 1'b0;
    end else if (!stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        hist_vld_q[i]  <= hist_vld_q[i-1];
        hist_addr_q[i] <= hist_addr_q[i-1];
        hist_data_q[i] <= hist_data_q[i-1];
      end
      hist_vld_q[0]  <= wr_en_in && (wr_addr_in != '0);
      hist_addr_q[0] <= wr_addr_in;
      hist_data_q[0] <= wr_data_in;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sel_rs_q <= sel_rs_d;
      sel_rt_q <= sel_rt_d;
      op_vld_q <= op_valid_in;
      if (op_valid_in) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign op1_out      = op1_q;
  assign op2_out      = op2_q;
  assign fwd_sel_rs   = sel_rs_q;
  assign fwd_sel_rt   = sel_rt_q;
  assign op_valid_out = op_vld_q;
  assign fwd_count    = cnt_q;

endmodule

// File: tb/tb_fwd_history_mux.sv
// Bench for fwd_history_mux: a reference model predicts every cycle's outputs into a queue that is
// compared after each edge, plus directed checks of the key forwarding scenarios.
module tb_fwd_history_mux;

  localparam int unsigned Depth = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en_in = 1'b0;
  logic [4:0]  wr_addr_in = '0;
  logic [31:0] wr_data_in = '0;
  logic        op_valid_in = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [31:0] rs_data = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] op1_out, op2_out;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;
  logic        op_valid_out;
  logic [15:0] fwd_count;

  fwd_history_mux #(
    .WIDTH (32),
    .DEPTH (Depth),
    .ADDR_W(5)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .wr_en_in    (wr_en_in),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (wr_data_in),
    .op_valid_in (op_valid_in),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rt_addr     (rt_addr),
    .rt_data     (rt_data),
    .op1_out     (op1_out),
    .op2_out     (op2_out),
    .fwd_sel_rs  (fwd_sel_rs),
    .fwd_sel_rt  (fwd_sel_rt),
    .op_valid_out(op_valid_out),
    .fwd_count   (fwd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  string tname = "init";

  logic [84:0] exp_q [$];

  // Reference model state
  logic        m_vld  [Depth];
  logic [4:0]  m_addr [Depth];
  logic [31:0] m_data [Depth];
  logic [31:0] e_op1 = '0, e_op2 = '0;
  logic [1:0]  e_srs = '0, e_srt = '0;
  logic        e_vld = 1'b0;
  int          e_cnt = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", tname, tag, obs, exp_v);
    end
  endtask

  task automatic model_lookup(input logic [4:0] a, input logic [31:0] rf,
                              output logic [1:0] sel, output logic [31:0] d);
    sel = 2'd0;
    d   = rf;
    if (a != 5'd0) begin
      for (int i = 0; i < Depth; i++) begin
        if (sel == 2'd0 && m_vld[i] && m_addr[i] == a) begin
          sel = 2'(i + 1);
          d   = m_data[i];
        end
      end
    end
  endtask

  task automatic cyc(input logic rn, input logic st, input logic fl, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic ov,
                     input logic [4:0] ra, input logic [31:0] rd,
                     input logic [4:0] ta, input logic [31:0] td);
    logic [1:0]  s1, s2;
    logic [31:0] d1, d2;
    logic [84:0] obs;
    @(negedge clk);
    rst_n = rn; stall = st; flush = fl;
    wr_en_in = we; wr_addr_in = wa; wr_data_in = wd;
    op_valid_in = ov; rs_addr = ra; rs_data = rd; rt_addr = ta; rt_data = td;
    if (!rn) begin
      for (int i = 0; i < Depth; i++) begin
        m_vld[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      end
      e_op1 = '0; e_op2 = '0; e_srs = '0; e_srt = '0; e_vld = 1'b0; e_cnt = 0;
    end else if (fl) begin
      for (int i = 0; i < Depth; i++) m_vld[i] = 1'b0;
      e_op1 = '0; e_op2 = '0; e_srs = '0; e_srt = '0; e_vld = 1'b0;
    end else if (!st) begin
      model_lookup(ra, rd, s1, d1);
      model_lookup(ta, td, s2, d2);
      e_op1 = d1; e_op2 = d2; e_srs = s1; e_srt = s2; e_vld = ov;
      if (ov) begin
        e_cnt = e_cnt + int'(s1 != 2'd0) + int'(s2 != 2'd0);
        if (e_cnt > 65535) e_cnt = 65535;
      end
      for (int i = Depth - 1; i > 0; i--) begin
        m_vld[i] = m_vld[i-1]; m_addr[i] = m_addr[i-1]; m_data[i] = m_data[i-1];
      end
      m_vld[0] = we && (wa != 5'd0); m_addr[0] = wa; m_data[0] = wd;
    end
    exp_q.push_back({e_op1, e_op2, e_srs, e_srt, e_vld, 16'(e_cnt)});
    @(posedge clk);
    #1;
    obs = {op1_out, op2_out, fwd_sel_rs, fwd_sel_rt, op_valid_out, fwd_count};
    check_eq("sb", obs, exp_q.pop_front());
  endtask

  initial begin
    // T1: reset overrides stall and flush
    tname = "t1";
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h5, 1'b1, 5'd3, 32'h1, 5'd3, 32'h2);
    check_eq("op1", op1_out, 0);
    check_eq("op2", op2_out, 0);
    check_eq("sel", {fwd_sel_rs, fwd_sel_rt}, 0);
    check_eq("vld", op_valid_out, 0);
    check_eq("cnt", fwd_count, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h55, 5'd3, 32'h66);
    check_eq("sel0", fwd_sel_rs, 0);
    check_eq("op1_rf", op1_out, 32'h55);

    // T2: write ages through the history, then falls out
    tname = "t2";
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hAA, 5'd0, 32'h0);
      check_eq($sformatf("sel_age%0d", k), fwd_sel_rs, (k <= 3) ? k : 0);
      check_eq($sformatf("op1_age%0d", k), op1_out, (k <= 3) ? 32'h11 : 32'hAA);
    end
    check_eq("cnt", fwd_count, 3);

    // T3: newest of two writes to the same register wins
    tname = "t3";
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB1, 5'd9, 32'hB2);
    check_eq("sel", {fwd_sel_rs, fwd_sel_rt}, 4'b0101);
    check_eq("ops", {op1_out, op2_out}, {32'h2, 32'h2});
    check_eq("cnt", fwd_count, 5);

    // T4: $zero is never forwarded
    tname = "t4";
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0);
    check_eq("sel", {fwd_sel_rs, fwd_sel_rt}, 0);
    check_eq("op1", op1_out, 0);
    check_eq("vld", op_valid_out, 1);
    check_eq("cnt", fwd_count, 5);

    // T5: stall freezes everything, flush clears history and validity
    tname = "t5";
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7, 1'b1, 5'd5, 32'h99, 5'd0, 32'h0);
    check_eq("same_cycle", {fwd_sel_rs, op1_out}, {2'd0, 32'h99});
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h9, 1'b1, 5'd5, 32'h77, 5'd5, 32'h78);
      check_eq("frozen", {fwd_sel_rs, fwd_sel_rt, op1_out, op2_out}, {4'd0, 32'h99, 32'h0});
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h77, 5'd0, 32'h0);
    check_eq("release", {fwd_sel_rs, op1_out}, {2'd1, 32'h7});
    check_eq("cnt", fwd_count, 6);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h9, 1'b1, 5'd5, 32'h77, 5'd0, 32'h0);
    check_eq("flush_vld", op_valid_out, 0);
    check_eq("flush_op1", op1_out, 0);
    check_eq("flush_cnt", fwd_count, 6);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h44, 5'd0, 32'h0);
    check_eq("post_flush", {fwd_sel_rs, op1_out}, {2'd0, 32'h44});

    // T6: forward count saturates and holds
    tname = "t6";
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int k = 0; k < 32800; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h5, 1'b1, 5'd9, 32'h1, 5'd9, 32'h2);
    end
    check_eq("sat", fwd_count, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h5, 1'b1, 5'd9, 32'h1, 5'd9, 32'h2);
      check_eq("sat_hold", fwd_count, 16'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
